// File: rtl/param_accu_hs_if.sv
// ============================================================================
// Module      : param_accu_hs_if
// Description : Valid/ready stream bundle for param_accu_hs (sample in, sum out).
//               ACCU_FLUSH_EN adds the last_in / cnt_out pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_accu_hs_if #(
    parameter int DATA_W  = 8,
    parameter int ACC_NUM = 4
) ();
    localparam int OUT_W = DATA_W + $clog2(ACC_NUM);

    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_in;
    logic [OUT_W-1:0]  data_out;
    logic              valid_out;
    logic              ready_out;
`ifdef ACCU_FLUSH_EN
    localparam int CNT_W = $clog2(ACC_NUM) + 1;
    logic              last_in;
    logic [CNT_W-1:0]  cnt_out;
`endif

    // Producer/consumer side that surrounds the accumulator
    modport master (
`ifdef ACCU_FLUSH_EN
        output last_in,
        input  cnt_out,
`endif
        output data_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out
    );

    modport slave (
`ifdef ACCU_FLUSH_EN
        input  last_in,
        output cnt_out,
`endif
        input  data_in, valid_in, ready_out,
        output ready_in, data_out, valid_out
    );
endinterface

`default_nettype wire

// File: rtl/param_accu_hs.sv
// ============================================================================
// Module      : param_accu_hs
// Description : Sums groups of ACC_NUM unsigned samples with valid/ready on both
//               sides; optional early group close via macro ACCU_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_accu_hs #(
    parameter int DATA_W  = 8,
    parameter int ACC_NUM = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    param_accu_hs_if.slave  bus
);
    localparam int OUT_W = DATA_W + $clog2(ACC_NUM);
    localparam int CNT_W = $clog2(ACC_NUM) + 1;
    localparam int EXT_W = OUT_W - DATA_W;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ACC_NUM - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [OUT_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_data_out;
    logic             r_valid_out;

    logic             w_complete;
    logic             w_ready_in;
    logic             w_acc;
    logic             w_take;
    logic [OUT_W-1:0] w_sum_next;

`ifdef ACCU_FLUSH_EN
    logic [CNT_W-1:0] r_cnt_out;
    assign w_complete  = (r_cnt == c_cnt_last) || bus.last_in;
    assign bus.cnt_out = r_cnt_out;
`else
    assign w_complete  = (r_cnt == c_cnt_last);
`endif

    // Only a completing beat can stall: it needs the output register free
    assign w_ready_in = !(w_complete && r_valid_out && !bus.ready_out);
    assign w_acc      = bus.valid_in && w_ready_in;
    assign w_take     = r_valid_out && bus.ready_out;
    assign w_sum_next = r_sum + {{EXT_W{1'b0}}, bus.data_in};

    assign bus.ready_in  = w_ready_in;
    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_cnt       <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
`ifdef ACCU_FLUSH_EN
            r_cnt_out   <= '0;
`endif
        end else begin
            if (w_take) begin
                r_valid_out <= 1'b0;
            end
            // A completing accept overrides the clear above, giving bubble-free groups
            if (w_acc) begin
                if (w_complete) begin
                    r_data_out  <= w_sum_next;
                    r_valid_out <= 1'b1;
                    r_sum       <= '0;
                    r_cnt       <= '0;
`ifdef ACCU_FLUSH_EN
                    r_cnt_out   <= r_cnt + c_cnt_one;
`endif
                end else begin
                    r_sum <= w_sum_next;
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_param_accu_hs.sv
// ============================================================================
// Module      : tb_param_accu_hs
// Description : Directed self-checking bench for param_accu_hs (8b/4 and 4b/8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_accu_hs;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   takes_a;

    param_accu_hs_if #(.DATA_W(8), .ACC_NUM(4)) bus_a ();
    param_accu_hs_if #(.DATA_W(4), .ACC_NUM(8)) bus_b ();

    param_accu_hs #(.DATA_W(8), .ACC_NUM(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    param_accu_hs #(.DATA_W(4), .ACC_NUM(8)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) takes_a <= 0;
        else if (bus_a.valid_out && bus_a.ready_out) takes_a <= takes_a + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat_a(input logic [7:0] d);
        bus_a.data_in  = d;
        bus_a.valid_in = 1'b1;
        @(posedge clk); #1;
        bus_a.valid_in = 1'b0;
    endtask

    task automatic beat_b(input logic [3:0] d);
        bus_b.data_in  = d;
        bus_b.valid_in = 1'b1;
        @(posedge clk); #1;
        bus_b.valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t0;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_a.data_in = '0; bus_a.valid_in = 1'b0; bus_a.ready_out = 1'b1;
        bus_b.data_in = '0; bus_b.valid_in = 1'b0; bus_b.ready_out = 1'b1;
`ifdef ACCU_FLUSH_EN
        bus_a.last_in = 1'b0;
        bus_b.last_in = 1'b0;
`endif
        idle(2);
        chk("rst_valid_out", 32'(bus_a.valid_out), 0);
        chk("rst_data_out",  32'(bus_a.data_out),  0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_in",  32'(bus_a.ready_in),  1);

        // Basic contiguous stream
        t0 = takes_a;
        beat_a(1); beat_a(2); beat_a(3); beat_a(14);
        chk("basic1_valid", 32'(bus_a.valid_out), 1);
        chk("basic1_data",  32'(bus_a.data_out),  20);
        beat_a(5);
        chk("basic1_clear", 32'(bus_a.valid_out), 0);
        beat_a(2); beat_a(103); beat_a(4);
        chk("basic2_data",  32'(bus_a.data_out),  114);
        beat_a(5); beat_a(6); beat_a(3); beat_a(54);
        chk("basic3_data",  32'(bus_a.data_out),  68);
        idle(1);
        chk("basic_idle_valid", 32'(bus_a.valid_out), 0);
        chk("basic_takes", 32'(takes_a - t0), 3);

        // Max values and gapped input
        beat_a(255); beat_a(255); beat_a(255); beat_a(255);
        chk("max_data", 32'(bus_a.data_out), 1020);
        beat_a(1); idle(2); beat_a(2); idle(2); beat_a(3); idle(2);
        chk("gap_no_valid", 32'(bus_a.valid_out), 0);
        beat_a(14);
        chk("gap_data", 32'(bus_a.data_out), 20);
        chk("gap_valid", 32'(bus_a.valid_out), 1);
        idle(1);

        // Backpressure: 8 ones with output blocked
        t0 = takes_a;
        bus_a.ready_out = 1'b0;
        beat_a(1); beat_a(1); beat_a(1); beat_a(1);
        chk("bp_first_data", 32'(bus_a.data_out), 4);
        beat_a(1); beat_a(1); beat_a(1);
        chk("bp_ready_low", 32'(bus_a.ready_in), 0);
        bus_a.data_in = 8'd1; bus_a.valid_in = 1'b1;
        idle(2);
        chk("bp_hold_data",  32'(bus_a.data_out),  4);
        chk("bp_hold_valid", 32'(bus_a.valid_out), 1);
        chk("bp_still_stall", 32'(bus_a.ready_in), 0);
        bus_a.ready_out = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus_a.ready_in), 1);
        idle(1);
        bus_a.valid_in = 1'b0;
        chk("bp_second_valid", 32'(bus_a.valid_out), 1);
        chk("bp_second_data",  32'(bus_a.data_out),  4);
        idle(1);
        chk("bp_drained", 32'(bus_a.valid_out), 0);
        chk("bp_takes", 32'(takes_a - t0), 2);

        // Completion and take on the same edge
        t0 = takes_a;
        bus_a.ready_out = 1'b0;
        beat_a(10); beat_a(20); beat_a(30); beat_a(40);
        chk("sim_g1", 32'(bus_a.data_out), 100);
        beat_a(1); beat_a(1); beat_a(1);
        bus_a.ready_out = 1'b1;
        beat_a(1);
        bus_a.ready_out = 1'b0;
        chk("sim_g2_valid", 32'(bus_a.valid_out), 1);
        chk("sim_g2", 32'(bus_a.data_out), 4);
        beat_a(2); beat_a(2); beat_a(2);
        bus_a.ready_out = 1'b1;
        beat_a(2);
        chk("sim_g3_valid", 32'(bus_a.valid_out), 1);
        chk("sim_g3", 32'(bus_a.data_out), 8);
        idle(1);
        chk("sim_takes", 32'(takes_a - t0), 3);

        // Reset mid-group
        beat_a(7); beat_a(7);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus_a.valid_out), 0);
        idle(1);
        rst_n = 1'b1;
        beat_a(1); beat_a(1); beat_a(1); beat_a(1);
        chk("rst_mid_data", 32'(bus_a.data_out), 4);
        idle(1);

        // Reset while a result is held
        bus_a.ready_out = 1'b0;
        beat_a(50); beat_a(1); beat_a(1); beat_a(1);
        chk("rst_hold_pre", 32'(bus_a.valid_out), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_hold_valid", 32'(bus_a.valid_out), 0);
        chk("rst_hold_data",  32'(bus_a.data_out),  0);
        idle(1);
        rst_n = 1'b1;
        bus_a.ready_out = 1'b1;
        #1;

        // Second parameter set: 4-bit samples, 8 per group
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("p_no_early", 32'(bus_b.valid_out), 0);
            beat_b(4'd15);
        end
        chk("p_sum_max", 32'(bus_b.data_out), 120);
        chk("p_valid",   32'(bus_b.valid_out), 1);
`ifdef ACCU_FLUSH_EN
        chk("p_cnt_out", 32'(bus_b.cnt_out), 8);
        beat_b(4'd3);
        bus_b.last_in = 1'b1;
        beat_b(4'd4);
        bus_b.last_in = 1'b0;
        chk("flush_data",  32'(bus_b.data_out), 7);
        chk("flush_cnt",   32'(bus_b.cnt_out),  2);
        chk("flush_valid", 32'(bus_b.valid_out), 1);

        bus_a.last_in = 1'b1;
        beat_a(9);
        bus_a.last_in = 1'b0;
        chk("flush1_data", 32'(bus_a.data_out), 9);
        chk("flush1_cnt",  32'(bus_a.cnt_out),  1);
        bus_a.ready_out = 1'b0;
        bus_a.last_in = 1'b1;
        #1;
        chk("flush_stall", 32'(bus_a.ready_in), 0);
        bus_a.last_in = 1'b0;
        #1;
        chk("flush_nostall", 32'(bus_a.ready_in), 1);
        bus_a.ready_out = 1'b1;
`endif
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
